uart_rx_wb: RTL

Serial UART receiver that deserialises 8-bit frames from an asynchronous RX pin and delivers each valid byte as a single Wishbone classic write cycle. It sits upstream of `fifo`: its controller-side `wb` connects to the FIFO input, mirroring `uart_tx` on the transmit side. It includes a one-byte holding register, so a full frame of time is tolerated while the bus is stalled. Framing, parity and overrun faults are flagged and the offending byte is discarded.

---
 rtl/uart_rx_wb_if.sv | 11 +
 rtl/uart_rx_wb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_wb_if.sv
// rtl/uart_rx_wb_if.sv - Wishbone classic write link from the UART receiver to its downstream FIFO
interface uart_rx_wb_if;
    logic       cyc;
    logic       stb;
    logic       we;
    logic [7:0] dat;
    logic       ack;

    modport master (output cyc, output stb, output we, output dat, input ack);
    modport slave  (input cyc, input stb, input we, input dat, output ack);
endinterface

// File: rtl/uart_rx_wb.sv
// rtl/uart_rx_wb.sv - UART 8N1 receiver delivering each byte as a Wishbone classic write
// Define UART_RX_PARITY_EN for 8E1 framing with parity checking.
module uart_rx_wb #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         uart_rx,
    uart_rx_wb_if.master wb,
    output logic         frame_err,
    output logic         parity_err,
    output logic         overrun
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif
    localparam logic [3:0] LAST_BIT = 4'(NBITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_RESYNC = 3'd4;

    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       state;
    logic [TW-1:0]    timer;
    logic [3:0]       bit_cnt;
    logic [NBITS-1:0] shreg;
    logic             par_bad;
    logic             stop_tick;
    logic             byte_done;

    // Two-entry buffer: the bus slot drives the write cycle, the hold slot absorbs a stall.
    logic       bvalid;
    logic [7:0] dat_q;
    logic       full;
    logic [7:0] hold;
    logic       cyc_q;
    logic       ack_t;
    logic       b_v_n;
    logic [7:0] b_d_n;
    logic       h_v_n;
    logic [7:0] h_d_n;
    logic       ovr_n;

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;
    assign par_bad    = shreg[8] != (^shreg[7:0]);
    assign parity_err = parity_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign stop_tick = (state == S_STOP) && (timer == FULL_T);
    assign byte_done = stop_tick && rx_s && !par_bad;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= S_IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta   <= uart_rx;
            rx_s      <= rx_meta;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        timer <= '0;
                    end
                end
                S_START: begin
                    if (timer == HALF_T) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (timer == FULL_T) begin
                        timer <= '0;
                        shreg <= {rx_s, shreg[NBITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_STOP: begin
                    if (timer == FULL_T) begin
                        timer <= '0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= S_RESYNC;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= par_bad;
`endif
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_RESYNC: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        timer <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ack_t = cyc_q & wb.ack;

    // An ack frees the bus slot before the new byte is placed, so a collision never overruns.
    always_comb begin
        b_v_n = bvalid & ~ack_t;
        b_d_n = dat_q;
        h_v_n = full;
        h_d_n = hold;
        ovr_n = 1'b0;
        if (!b_v_n && h_v_n) begin
            b_v_n = 1'b1;
            b_d_n = h_d_n;
            h_v_n = 1'b0;
        end
        if (byte_done) begin
            if (!b_v_n) begin
                b_v_n = 1'b1;
                b_d_n = shreg[7:0];
            end else if (!h_v_n) begin
                h_v_n = 1'b1;
                h_d_n = shreg[7:0];
            end else begin
                ovr_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bvalid  <= 1'b0;
            dat_q   <= 8'h00;
            full    <= 1'b0;
            hold    <= 8'h00;
            cyc_q   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            bvalid  <= b_v_n;
            dat_q   <= b_d_n;
            full    <= h_v_n;
            hold    <= h_d_n;
            cyc_q   <= b_v_n & ~ack_t;
            overrun <= ovr_n;
        end
    end

    assign wb.cyc = cyc_q;
    assign wb.stb = cyc_q;
    assign wb.we  = cyc_q;
    assign wb.dat = dat_q;
endmodule
